tl_traffic_sensor: RTL

TL_TRAFFIC_SENSOR -- requirements
Module: tl_traffic_sensor

---
 rtl/tl_pkg.sv | 17 +
 rtl/tl_lane_queue.sv | 75 +++++++
 rtl/tl_traffic_sensor.sv | 65 ++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared traffic-light package: light encodings and lane indices used by the
// sensor block and the light controller.
package tl_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10,
        LEFT   = 2'b11
    } light_e;

    localparam int LANE_A  = 0;
    localparam int LANE_AL = 1;
    localparam int LANE_B  = 2;
    localparam int LANE_BL = 3;

endpackage

// File: rtl/tl_lane_queue.sv
// One lane of the traffic sensor: car queue, departure pacing and the
// optional sticky overflow flag (enabled by macro TL_SENSOR_OVF_EN).
module tl_lane_queue #(
    parameter int DEP_INTERVAL = 2,
    parameter int QW           = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arr,
    input  logic          permit,
    output logic [QW-1:0] q,
    output logic          dep,
    output logic          ovf
);

    localparam logic [3:0]    PACE_MAX = 4'(DEP_INTERVAL - 1);
    localparam logic [QW-1:0] Q_MAX    = {QW{1'b1}};

    logic [QW-1:0] q_q, q_d;
    logic [3:0]    pace_q, pace_d;
    logic          dep_q, dep_d;

    // A departure resets pacing; leaving the permitted state drops pace to zero.
    always_comb begin
        dep_d  = permit && (pace_q == PACE_MAX) && (q_q != '0);
        pace_d = '0;
        if (permit && !dep_d) begin
            pace_d = (pace_q == PACE_MAX) ? pace_q : pace_q + 4'd1;
        end
        q_d = q_q;
        if (arr && !dep_d && (q_q != Q_MAX)) begin
            q_d = q_q + QW'(1);
        end else if (dep_d && !arr) begin
            q_d = q_q - QW'(1);
        end
    end

`ifdef TL_SENSOR_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (arr && !dep_d && (q_q == Q_MAX)) begin
            ovf_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            pace_q <= '0;
            dep_q  <= 1'b0;
`ifdef TL_SENSOR_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            q_q    <= q_d;
            pace_q <= pace_d;
            dep_q  <= dep_d;
`ifdef TL_SENSOR_OVF_EN
            ovf_q  <= ovf_d;
`endif
        end
    end

    assign q   = q_q;
    assign dep = dep_q;
`ifdef TL_SENSOR_OVF_EN
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/tl_traffic_sensor.sv
// Four-lane car sensor feeding the light controller; optional overflow
// flags are enabled by macro TL_SENSOR_OVF_EN.
module tl_traffic_sensor
    import tl_pkg::*;
#(
    parameter int DEP_INTERVAL = 2,
    parameter int QW           = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arr_a,
    input  logic          arr_al,
    input  logic          arr_b,
    input  logic          arr_bl,
    input  logic [1:0]    La,
    input  logic [1:0]    Lb,
    output logic          Ta,
    output logic          Tal,
    output logic          Tb,
    output logic          Tbl,
    output logic [QW-1:0] q_a,
    output logic [QW-1:0] q_al,
    output logic [QW-1:0] q_b,
    output logic [QW-1:0] q_bl,
    output logic          dep_a,
    output logic          dep_al,
    output logic          dep_b,
    output logic          dep_bl,
    output logic [3:0]    ovf
);

    logic [3:0] permit;

    // Straight lanes move on GREEN, turn lanes on LEFT; YELLOW and RED hold all.
    assign permit[LANE_A]  = (La == GREEN);
    assign permit[LANE_AL] = (La == LEFT);
    assign permit[LANE_B]  = (Lb == GREEN);
    assign permit[LANE_BL] = (Lb == LEFT);

    tl_lane_queue #(.DEP_INTERVAL(DEP_INTERVAL), .QW(QW)) u_lane_a (
        .clk(clk), .reset(reset), .arr(arr_a), .permit(permit[LANE_A]),
        .q(q_a), .dep(dep_a), .ovf(ovf[LANE_A])
    );

    tl_lane_queue #(.DEP_INTERVAL(DEP_INTERVAL), .QW(QW)) u_lane_al (
        .clk(clk), .reset(reset), .arr(arr_al), .permit(permit[LANE_AL]),
        .q(q_al), .dep(dep_al), .ovf(ovf[LANE_AL])
    );

    tl_lane_queue #(.DEP_INTERVAL(DEP_INTERVAL), .QW(QW)) u_lane_b (
        .clk(clk), .reset(reset), .arr(arr_b), .permit(permit[LANE_B]),
        .q(q_b), .dep(dep_b), .ovf(ovf[LANE_B])
    );

    tl_lane_queue #(.DEP_INTERVAL(DEP_INTERVAL), .QW(QW)) u_lane_bl (
        .clk(clk), .reset(reset), .arr(arr_bl), .permit(permit[LANE_BL]),
        .q(q_bl), .dep(dep_bl), .ovf(ovf[LANE_BL])
    );

    assign Ta  = (q_a  != '0);
    assign Tal = (q_al != '0);
    assign Tb  = (q_b  != '0);
    assign Tbl = (q_bl != '0);

endmodule
